// File: rtl/lc3_mem_pkg.sv
// ---------------------------------------------------------------------------
// lc3_mem_pkg
// Shared types and widths for the RAM sequencer (mem_ctrl) and its arbiter.
//   state_t : controller FSM states IDLE / ACCESS / DONE
//   req_t   : requester identity, instruction fetch (REQ_F) or data (REQ_D)
//   ADDR_W / DATA_W : RAM address and data widths
// ---------------------------------------------------------------------------
package lc3_mem_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic {
    REQ_F = 1'b0,
    REQ_D = 1'b1
  } req_t;

endpackage

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Combinational grant select between the fetch and data requesters.
// Default build: fixed priority, data wins over fetch.
// With MEM_CTRL_RR_EN defined: round-robin on a tie, using a 1-bit
// last-winner register (reset to REQ_F) that is updated on i_update.
//
// Ports
//   i_clk, i_rst_n : clock / async active-low reset (MEM_CTRL_RR_EN only)
//   i_update       : winner is being accepted this cycle (MEM_CTRL_RR_EN only)
//   i_f_req        : fetch request level
//   i_d_req        : data request level
//   o_valid        : at least one request present
//   o_winner       : requester that wins this cycle
// ---------------------------------------------------------------------------
module mem_arbiter
  import lc3_mem_pkg::*;
(
`ifdef MEM_CTRL_RR_EN
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_update,
`endif
  input  logic i_f_req,
  input  logic i_d_req,
  output logic o_valid,
  output req_t o_winner
);

`ifdef MEM_CTRL_RR_EN
  req_t r_last;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last <= REQ_F;
    end else if (i_update) begin
      r_last <= o_winner;
    end
  end
`endif

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    o_valid  = i_f_req | i_d_req;
    o_winner = i_d_req ? REQ_D : REQ_F;
`ifdef MEM_CTRL_RR_EN
    // On a tie the requester that did not win last time goes first.
    if (i_f_req && i_d_req) begin
      o_winner = (r_last == REQ_D) ? REQ_F : REQ_D;
    end
`endif
  end

endmodule

// File: rtl/mem_ctrl.sv
// ---------------------------------------------------------------------------
// mem_ctrl
// Sequences a single-port RAM for two requesters (fetch F, data D).
// IDLE arbitrates and latches the winning request, ACCESS drives the RAM
// (reads wait for MEM_READY up to TIMEOUT cycles, writes hold for WR_CYCLES
// cycles), DONE pulses the winner's X_DONE for one cycle.
// Optional macro MEM_CTRL_RR_EN: round-robin arbitration on a tie instead of
// fixed data-over-fetch priority.
//
// Parameters
//   WR_CYCLES : cycles MEM_CS/MEM_WE stay asserted for a write (>=1)
//   TIMEOUT   : max ACCESS cycles a read waits for MEM_READY (>=2)
// Ports
//   CLK, RST_N                : clock, async active-low reset
//   F_REQ, F_ADDR             : fetch request (read only)
//   F_GNT, F_DONE             : fetch owns RAM / completion pulse
//   D_REQ, D_WE, D_ADDR, D_WDATA : data request
//   D_GNT, D_DONE             : data owns RAM / completion pulse
//   RDATA, ERR                : last read data, read-timeout flag
//   BUSY                      : controller not idle
//   MEM_ADDR, MEM_DIN, MEM_WE, MEM_CS : RAM control
//   MEM_DOUT, MEM_READY       : RAM read data / ready
// ---------------------------------------------------------------------------
module mem_ctrl
  import lc3_mem_pkg::*;
#(
  parameter int WR_CYCLES = 1,
  parameter int TIMEOUT   = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              F_REQ,
  input  logic [ADDR_W-1:0] F_ADDR,
  output logic              F_GNT,
  output logic              F_DONE,
  input  logic              D_REQ,
  input  logic              D_WE,
  input  logic [ADDR_W-1:0] D_ADDR,
  input  logic [DATA_W-1:0] D_WDATA,
  output logic              D_GNT,
  output logic              D_DONE,
  output logic [DATA_W-1:0] RDATA,
  output logic              ERR,
  output logic              BUSY,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_DIN,
  output logic              MEM_WE,
  output logic              MEM_CS,
  input  logic [DATA_W-1:0] MEM_DOUT,
  input  logic              MEM_READY
);

  localparam int CNT_MAX = (TIMEOUT > WR_CYCLES) ? TIMEOUT : WR_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t              r_state;
  state_t              w_next;
  req_t                r_id;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_we;
  logic                r_err;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_arb_valid;
  req_t                w_arb_winner;
  logic                w_start;
  logic                w_timeout;

  mem_arbiter u_arb (
`ifdef MEM_CTRL_RR_EN
    .i_clk    (CLK),
    .i_rst_n  (RST_N),
    .i_update (w_start),
`endif
    .i_f_req  (F_REQ),
    .i_d_req  (D_REQ),
    .o_valid  (w_arb_valid),
    .o_winner (w_arb_winner)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state plus outputs; all outputs decode registered state/latches
  // only, so the RAM strobes cannot glitch on requester activity.
  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_arb_valid) begin
          w_start = 1'b1;
          w_next  = ACCESS;
        end
      end
      ACCESS: begin
        if (r_we) begin
          if (r_cnt == CNT_W'(WR_CYCLES - 1)) w_next = DONE;
        end else if (MEM_READY) begin
          w_next = DONE;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_timeout = 1'b1;
          w_next    = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase

    BUSY     = (r_state != IDLE);
    MEM_CS   = (r_state == ACCESS);
    MEM_WE   = (r_state == ACCESS) && r_we;
    MEM_ADDR = r_addr;
    MEM_DIN  = r_wdata;
    F_GNT    = BUSY && (r_id == REQ_F);
    D_GNT    = BUSY && (r_id == REQ_D);
    F_DONE   = (r_state == DONE) && (r_id == REQ_F);
    D_DONE   = (r_state == DONE) && (r_id == REQ_D);
    RDATA    = r_rdata;
    ERR      = r_err;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_id    <= REQ_F;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else if (w_start) begin
      r_id   <= w_arb_winner;
      r_cnt  <= '0;
      r_err  <= 1'b0;
      if (w_arb_winner == REQ_D) begin
        r_addr  <= D_ADDR;
        r_we    <= D_WE;
        r_wdata <= D_WDATA;
      end else begin
        // Fetch is always a read; the write-data latch keeps its last value.
        r_addr <= F_ADDR;
        r_we   <= 1'b0;
      end
    end else if (r_state == ACCESS) begin
      r_cnt <= r_cnt + 1'b1;
      if (!r_we && MEM_READY) begin
        r_rdata <= MEM_DOUT;
      end else if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule
